// File: rtl/sram_arbiter.sv
// ============================================================================
// Module      : sram_arbiter
// Description : Three-port arbiter and SETUP/ACCESS/HOLD sequencer for an 8-bit
//               asynchronous SRAM. Optional CPU/DMA round-robin: SRAM_ARB_ROUND_ROBIN_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W        = 21,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk_chipset,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              cpu_we,
    input  logic              dma_we,
    input  logic [7:0]        cpu_wdata,
    input  logic [7:0]        dma_wdata,
    output logic              vid_ack,
    output logic              cpu_ack,
    output logic              dma_ack,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] C_ID_VID   = 2'd0;
    localparam logic [1:0] C_ID_CPU   = 2'd1;
    localparam logic [1:0] C_ID_DMA   = 2'd2;
    localparam logic [3:0] C_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [1:0]          r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;

    logic                w_gnt_valid;
    logic                w_pick_dma;
    logic [1:0]          w_gnt_id;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_gnt_we;
    logic [7:0]          w_gnt_wdata;
    logic                w_we_nxt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Set when DMA holds the round-robin turn; CPU holds it out of reset.
    logic                r_rr_dma;

    assign w_pick_dma = dma_req && (!cpu_req || r_rr_dma);
`else
    assign w_pick_dma = dma_req && !cpu_req;
`endif

    assign w_gnt_valid = vid_req || cpu_req || dma_req;

    always_comb begin
        w_gnt_id    = C_ID_VID;
        w_gnt_addr  = vid_addr;
        w_gnt_we    = 1'b0;
        w_gnt_wdata = 8'h00;
        if (vid_req) begin
            w_gnt_id    = C_ID_VID;
            w_gnt_addr  = vid_addr;
        end else if (w_pick_dma) begin
            w_gnt_id    = C_ID_DMA;
            w_gnt_addr  = dma_addr;
            w_gnt_we    = dma_we;
            w_gnt_wdata = dma_wdata;
        end else if (cpu_req) begin
            w_gnt_id    = C_ID_CPU;
            w_gnt_addr  = cpu_addr;
            w_gnt_we    = cpu_we;
            w_gnt_wdata = cpu_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the SRAM pins never glitch.
    assign w_we_nxt  = (r_state == IDLE) ? w_gnt_we : r_we;
    assign sram_addr = r_addr;
    assign sram_dq_o = r_wdata;

    always_ff @(posedge clk_chipset) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_id       <= C_ID_VID;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
            rdata      <= 8'h00;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_gnt_valid) begin
                r_id    <= w_gnt_id;
                r_addr  <= w_gnt_addr;
                r_we    <= w_gnt_we;
                r_wdata <= w_gnt_wdata;
            end
            if (r_state == SETUP) begin
                r_cnt <= C_CNT_LOAD;
            end else if (r_state == ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ACCESS && r_cnt == 4'd0 && !r_we) begin
                rdata <= sram_dq_i;
            end
            sram_we_n  <= !((w_state_nxt == ACCESS) && w_we_nxt);
            sram_dq_oe <= (w_state_nxt != IDLE) && w_we_nxt;
            vid_ack    <= (w_state_nxt == HOLD) && (r_id == C_ID_VID);
            cpu_ack    <= (w_state_nxt == HOLD) && (r_id == C_ID_CPU);
            dma_ack    <= (w_state_nxt == HOLD) && (r_id == C_ID_DMA);
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_chipset) begin
        if (!reset_n) begin
            r_rr_dma <= 1'b0;
        end else if (r_state == IDLE && !vid_req && (cpu_req || dma_req)) begin
            r_rr_dma <= (w_gnt_id == C_ID_CPU);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter with a small SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic        clk_chipset;
    logic        reset_n;
    logic        vid_req, cpu_req, dma_req;
    logic [20:0] vid_addr, cpu_addr, dma_addr;
    logic        cpu_we, dma_we;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        vid_ack, cpu_ack, dma_ack;
    logic [7:0]  rdata;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_i;
    logic        sram_we_n;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         id;
        logic [7:0] rd;
        int         cyc;
    } exp_t;
    exp_t q[$];

    logic [7:0] mem [256];

    sram_arbiter dut (
        .clk_chipset (clk_chipset),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .vid_addr    (vid_addr),
        .cpu_addr    (cpu_addr),
        .dma_addr    (dma_addr),
        .cpu_we      (cpu_we),
        .dma_we      (dma_we),
        .cpu_wdata   (cpu_wdata),
        .dma_wdata   (dma_wdata),
        .vid_ack     (vid_ack),
        .cpu_ack     (cpu_ack),
        .dma_ack     (dma_ack),
        .rdata       (rdata),
        .sram_addr   (sram_addr),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_i   (sram_dq_i),
        .sram_we_n   (sram_we_n)
    );

    initial begin
        clk_chipset = 1'b0;
        forever #10 clk_chipset = ~clk_chipset;
    end

    always @(posedge clk_chipset) cyc <= cyc + 1;

    // SRAM model: 256-byte alias of the low address bits, preset to ~addr.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
    end
    always @(posedge clk_chipset) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] = sram_dq_o;
    end
    assign sram_dq_i = mem[sram_addr[7:0]];

    // Monitor: every ack pops one expectation (port, cycle, rdata).
    always @(negedge clk_chipset) begin
        logic [2:0] ackv;
        exp_t       e;
        ackv = {dma_ack, cpu_ack, vid_ack};
        if (ackv != 3'b000) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack ack=%b cyc=%0d", ackv, cyc);
            end else begin
                e = q.pop_front();
                if (ackv != 3'(1 << e.id) || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL ack_order_timing ack=%b cyc=%0d required ack=%b cyc=%0d",
                             ackv, cyc, 3'(1 << e.id), e.cyc);
                end
                checks++;
                if (rdata !== e.rd) begin
                    failures++;
                    $display("FAIL rdata got=%h required=%h cyc=%0d", rdata, e.rd, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_chipset);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] rd, input int c);
        exp_t e;
        e.id = id; e.rd = rd; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    // Requester agent: holds req for n acks, drops it on the edge after the last.
    task automatic access(input int port, input logic we, input logic [20:0] a,
                          input logic [7:0] d, input int n);
        int   got    = 0;
        int   budget = 0;
        logic ack;
        case (port)
            0: begin vid_addr = a; vid_req = 1'b1; end
            1: begin cpu_addr = a; cpu_we = we; cpu_wdata = d; cpu_req = 1'b1; end
            default: begin dma_addr = a; dma_we = we; dma_wdata = d; dma_req = 1'b1; end
        endcase
        while (got < n && budget < 200) begin
            @(negedge clk_chipset);
            budget++;
            case (port)
                0:       ack = vid_ack;
                1:       ack = cpu_ack;
                default: ack = dma_ack;
            endcase
            if (ack) got++;
        end
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout port=%0d got=%0d required=%0d", port, got, n);
        end
        @(posedge clk_chipset);
        #1;
        case (port)
            0:       vid_req = 1'b0;
            1:       cpu_req = 1'b0;
            default: dma_req = 1'b0;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n0;
        logic [4:0] exp_wen;
        logic [4:0] exp_oe;
        exp_wen = 5'b11001;   // bit k-1 = cycle k
        exp_oe  = 5'b01111;

        reset_n = 1'b0;
        vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        vid_addr = '0; cpu_addr = '0; dma_addr = '0;
        cpu_we = 1'b0; dma_we = 1'b0; cpu_wdata = 8'h00; dma_wdata = 8'h00;
        tick(3);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_oe", 32'(sram_dq_oe), 32'd0);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        chk("reset_dq_o", 32'(sram_dq_o), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // CPU write: strobe waveform cycle by cycle.
        n0 = cyc;
        push(1, 8'h00, n0 + 4);
        fork
            access(1, 1'b1, 21'h1ABCD, 8'h5A, 1);
            begin
                @(negedge clk_chipset);
                for (int k = 1; k <= 5; k++) begin
                    @(negedge clk_chipset);
                    chk($sformatf("wr_we_n_c%0d", k), 32'(sram_we_n), 32'(exp_wen[k-1]));
                    chk($sformatf("wr_oe_c%0d", k), 32'(sram_dq_oe), 32'(exp_oe[k-1]));
                    chk($sformatf("wr_addr_c%0d", k), 32'(sram_addr), 32'h1ABCD);
                end
            end
        join
        chk("wr_data_in_sram", 32'(mem[8'hCD]), 32'h5A);

        // CPU read back; bus never driven.
        n0 = cyc;
        push(1, 8'h5A, n0 + 4);
        fork
            access(1, 1'b0, 21'h1ABCD, 8'h00, 1);
            begin
                @(negedge clk_chipset);
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk_chipset);
                    chk($sformatf("rd_oe_c%0d", k), 32'(sram_dq_oe), 32'd0);
                    chk($sformatf("rd_we_n_c%0d", k), 32'(sram_we_n), 32'd1);
                end
            end
        join

        // All three at once: video, CPU, DMA, 5 cycles apart; write keeps rdata.
        do_reset();
        n0 = cyc;
        push(0, 8'hEE, n0 + 4);
        push(1, 8'hEE, n0 + 9);
        push(2, 8'h5A, n0 + 14);
        fork
            access(0, 1'b0, 21'h00011, 8'h00, 1);
            access(1, 1'b1, 21'h00022, 8'hC3, 1);
            access(2, 1'b0, 21'h1ABCD, 8'h00, 1);
        join
        chk("tri_write_in_sram", 32'(mem[8'h22]), 32'hC3);

        // CPU and DMA both held for two accesses each.
        do_reset();
        n0 = cyc;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        push(1, 8'hCC, n0 + 4);
        push(2, 8'hBB, n0 + 9);
        push(1, 8'hCC, n0 + 14);
        push(2, 8'hBB, n0 + 19);
`else
        push(1, 8'hCC, n0 + 4);
        push(1, 8'hCC, n0 + 9);
        push(2, 8'hBB, n0 + 14);
        push(2, 8'hBB, n0 + 19);
`endif
        fork
            access(1, 1'b0, 21'h00033, 8'h00, 2);
            access(2, 1'b0, 21'h00044, 8'h00, 2);
        join

        // Video arrives during DMA ACCESS: no preemption.
        n0 = cyc;
        push(2, 8'hAA, n0 + 4);
        push(0, 8'h99, n0 + 9);
        fork
            access(2, 1'b0, 21'h00055, 8'h00, 1);
            begin
                tick(2);
                access(0, 1'b0, 21'h00066, 8'h00, 1);
            end
        join

        // Reset during a write's ACCESS window.
        cpu_addr = 21'h00077; cpu_we = 1'b1; cpu_wdata = 8'h99; cpu_req = 1'b1;
        repeat (3) @(negedge clk_chipset);
        chk("rst_pre_we_n", 32'(sram_we_n), 32'd0);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk_chipset);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        @(posedge clk_chipset);
        #1;
        reset_n = 1'b1;
        n0 = cyc;
        push(1, 8'hED, n0 + 4);
        access(1, 1'b0, 21'h00012, 8'h00, 1);

        tick(3);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and arbiter for the shared external 8-bit asynchronous SRAM: 2 MB, 21-bit address, single active-low write enable. It grants the SRAM to one of three requesters: video fetch, CPU bus and DMA. It drives the address, data and write-enable lines through a SETUP/ACCESS/HOLD strobe sequence. It sits in the 50 MHz chipset domain between the system bus logic and the board SRAM pins. The parent instantiates the data-bus tristate from `sram_dq_o`/`sram_dq_oe`.

## Interface
Parameters:
- `ADDR_W`, 21: SRAM address width.
- `ACCESS_CYCLES`, 2: cycles in ACCESS state. Legal range 1..15.

Ports:
- `clk_chipset`  in  1  chipset clock. Sole clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `vid_req`, `cpu_req`, `dma_req`  in  1 each  access request. Level-held until the matching ack.
- `vid_addr`, `cpu_addr`, `dma_addr`  in  ADDR_W each  byte address.
- `cpu_we`, `dma_we`  in  1 each  1 = write, 0 = read. The video port is read-only.
- `cpu_wdata`, `dma_wdata`  in  8 each  write data.
- `vid_ack`, `cpu_ack`, `dma_ack`  out  1 each  one-cycle completion pulse.
- `rdata`  out  8  read data. Valid in the ack cycle and held until the next read completes.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_dq_o`  out  8  SRAM write data.
- `sram_dq_oe`  out  1  data bus output enable.
- `sram_dq_i`  in  8  SRAM read data.
- `sram_we_n`  out  1  SRAM write enable, active-low.

## Operation
State machine states: IDLE, SETUP, ACCESS, HOLD.

IDLE:
- Arbitrates among the asserted requests.
- Priority: video is always highest; CPU and DMA ranking is set per Configuration.
- Latches the winner's id, addr, we and wdata into internal registers, then goes to SETUP.
- With no request asserted, stays in IDLE.

SETUP (1 cycle):
- `sram_addr` = latched address.
- Write: `sram_dq_o` = wdata and `sram_dq_oe` = 1.
- `sram_we_n` = 1.

ACCESS (ACCESS_CYCLES cycles, down-counter):
- Write: `sram_we_n` = 0.
- Read: `sram_dq_oe` = 0; `sram_dq_i` is registered into `rdata` on the final ACCESS cycle.

HOLD (1 cycle):
- `sram_we_n` = 1.
- Address and write data are still driven, giving data/address hold time.
- The winner's ack is 1.
- HOLD always returns to IDLE.

Handshake and boundary conditions:
- Requester fields must remain stable while req is high.
- The requester must drop req at the clock edge on which it samples ack; a registered requester does this naturally. A req still high in the following IDLE cycle is a new access.
- Requests arriving during SETUP/ACCESS/HOLD wait. No preemption: a video request never aborts an in-flight CPU/DMA access.
- At most one ack is high per cycle.
- `rdata` is not updated by writes.
- Address wrap-around is not applicable: addresses pass through unmodified.

## Timing
- Latency from the edge on which IDLE samples req to the ack cycle: 2 + ACCESS_CYCLES cycles. Default: 4 cycles, i.e. 80 ns at 50 MHz.
- Back-to-back throughput: one access every 3 + ACCESS_CYCLES cycles; the IDLE cycle is the bus turnaround.
- `sram_we_n` low width = ACCESS_CYCLES cycles. Address is stable 1 cycle before and 1 cycle after the WE low window.
- `sram_dq_oe` is 0 in IDLE and in all read states, so there is no bus contention on read-after-write.
- Reset values:
  - state IDLE, counter 0
  - `sram_we_n` = 1, `sram_dq_oe` = 0
  - `sram_addr` = 0, `sram_dq_o` = 0
  - `rdata` = 0, all acks = 0
  - round-robin pointer = CPU
- Reset mid-operation: at the next edge with `reset_n` = 0, `sram_we_n` goes to 1 and `sram_dq_oe` to 0. No ack is issued and an in-progress write may be partial.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - CPU and DMA share the second priority level in round-robin.
  - The pointer toggles to the other requester after every granted CPU or DMA access.
  - On simultaneous CPU+DMA requests, the requester not served last wins.
- Undefined: fixed priority, video > CPU > DMA. The pointer logic is not built.

## Test plan
- Reset, then CPU write addr 0x1ABCD data 0x5A (ACCESS_CYCLES=2):
  - WE_n low for exactly cycles 2-3 after sampling.
  - Address stable cycles 1-4, oe 1 in cycles 1-4.
  - `cpu_ack` pulses in cycle 4.
- CPU read of 0x1ABCD with SRAM model: `rdata` = 0x5A in the `cpu_ack` cycle, `sram_dq_oe` = 0 throughout, latency 4.
- Video, CPU and DMA requests all asserted in the same IDLE cycle: order of acks is video, then CPU, then DMA. Consecutive acks are 5 cycles apart.
- CPU and DMA held continuously requesting, two acks each:
  - With `SRAM_ARB_ROUND_ROBIN_EN`: order CPU, DMA, CPU, DMA.
  - Without: CPU, CPU while CPU keeps requesting.
- Video request rises during a DMA ACCESS: DMA completes with unchanged timing, then video is granted in the next IDLE.
- `reset_n` low during a write's ACCESS cycle: next edge gives `sram_we_n` = 1 and `sram_dq_oe` = 0. No ack appears, and the state is IDLE after release.
